param_updown_counter: RTL and testbench

//   Parametrised up/down counter, the successor to the fixed 4-bit up-counter.

---
 rtl/counter_pkg.sv | 7 +
 rtl/param_updown_counter.sv | 56 +++++
 tb/tb_param_updown_counter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction and boundary-mode constants for the counter family
package counter_pkg;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
endpackage

// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down counter over 0..MAX_VAL with load, wrap/saturate, tc strobe and sticky overflow
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] max_c = WIDTH'(MAX_VAL);
  localparam logic sat = (SATURATE == MODE_SAT);
  if (WIDTH < 1) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be >= 1");
  end
  if (MAX_VAL > 2**WIDTH-1) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL exceeds 2**WIDTH-1");
  end
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] load_c;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  // next count and overflow: bounds compared against MAX_VAL, never natural rollover
  always_comb begin
    at_top    = (count == max_c);
    at_bot    = (count == '0);
    tc        = en & ((up_dn == CNT_UP) ? at_top : at_bot);
    load_c    = (load_val > max_c) ? max_c : load_val;
    step      = (up_dn == CNT_UP)
                ? (at_top ? (sat ? max_c : '0) : count + WIDTH'(1))
                : (at_bot ? (sat ? '0 : max_c) : count - WIDTH'(1));
    count_nxt = load ? load_c : en ? step : count;
    ovf_nxt   = (tc & ~load) | (ovf & ~clr_ovf);
  end
  // state register with synchronous active-low reset overriding load and count
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: scoreboarded directed and random checks on wrap, saturate and 8-bit counters
module tb_param_updown_counter;
  logic clk = 0, rst = 0, en = 0, up_dn = 1, load = 0, clr_ovf = 0;
  logic [7:0] lv = 0;
  logic [3:0] cnt_a, cnt_b;
  logic [7:0] cnt_c;
  logic tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;
  int total = 0, bad = 0;
  int mc[3], mo[3];
  int mx[3] = '{9, 9, 255};
  int sat[3] = '{0, 1, 0};
  typedef struct {int k; int c; int o;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[3:0]),
    .clr_ovf(clr_ovf), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[3:0]),
    .clr_ovf(clr_ovf), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));
  param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv),
    .clr_ovf(clr_ovf), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));
  function automatic logic [8:0] obs_c(int k);
    return k == 0 ? {5'b0, cnt_a} : k == 1 ? {5'b0, cnt_b} : {1'b0, cnt_c};
  endfunction
  function automatic logic obs_o(int k);
    return k == 0 ? ovf_a : k == 1 ? ovf_b : ovf_c;
  endfunction
  function automatic logic obs_t(int k);
    return k == 0 ? tc_a : k == 1 ? tc_b : tc_c;
  endfunction
  function automatic int mtc(int k);
    return (en && ((up_dn && mc[k] == mx[k]) || (!up_dn && mc[k] == 0))) ? 1 : 0;
  endfunction
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [7:0] v, input logic c);
    int nc, lk, t;
    exp_t x;
    rst = r; en = e; up_dn = u; load = l; lv = v; clr_ovf = c;
    #1;
    for (int k = 0; k < 3; k++) begin
      t = mtc(k);
      chk($sformatf("tc%0d", k), {8'b0, obs_t(k)}, 9'(t));
      lk = k < 2 ? int'(v[3:0]) : int'(v);
      if (!r) nc = 0;
      else if (l) nc = lk > mx[k] ? mx[k] : lk;
      else if (e && t != 0) nc = sat[k] != 0 ? mc[k] : (u ? 0 : mx[k]);
      else if (e) nc = u ? (mc[k] + 1) % (mx[k] + 1) : mc[k] - 1;
      else nc = mc[k];
      mo[k] = !r ? 0 : (!l && t != 0) ? 1 : c ? 0 : mo[k];
      mc[k] = nc;
      q.push_back('{k, nc, mo[k]});
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      chk($sformatf("cnt%0d", x.k), obs_c(x.k), 9'(x.c));
      chk($sformatf("ovf%0d", x.k), {8'b0, obs_o(x.k)}, 9'(x.o));
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 0; en = 1; up_dn = 1; load = 1; lv = 8'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      mc[k] = 0;
      mo[k] = 0;
      chk($sformatf("rst_cnt%0d", k), obs_c(k), 9'd0);
      chk($sformatf("rst_ovf%0d", k), {8'b0, obs_o(k)}, 9'd0);
    end
    load = 0; up_dn = 0;
    #1 chk("rst_tc_dn", {8'b0, tc_a}, 9'd1);
    repeat (12) step(1, 1, 1, 0, 0, 0);
    chk("t1_cnt", obs_c(0), 9'd2);
    chk("t1_ovf", {8'b0, ovf_a}, 9'd1);
    step(1, 1, 1, 1, 8'd4, 0);
    chk("t2_load4", obs_c(0), 9'd4);
    step(1, 1, 1, 1, 8'd13, 0);
    chk("t2_clamp", obs_c(0), 9'd9);
    chk("t2_ovf_kept", {8'b0, ovf_a}, 9'd1);
    step(1, 0, 1, 0, 0, 1);
    chk("t3_clr", {8'b0, ovf_a}, 9'd0);
    step(1, 1, 1, 1, 8'd0, 0);
    en = 1; up_dn = 0;
    #1 chk("t3_tc", {8'b0, tc_a}, 9'd1);
    step(1, 1, 0, 0, 0, 0);
    chk("t3_under", obs_c(0), 9'd9);
    chk("t3_ovf", {8'b0, ovf_a}, 9'd1);
    chk("t3_sat_hold0", obs_c(1), 9'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("t3_clr2", {8'b0, ovf_a}, 9'd0);
    step(1, 1, 1, 1, 8'd9, 0);
    repeat (3) step(1, 1, 1, 0, 0, 0);
    chk("t4_sat_cnt", obs_c(1), 9'd9);
    chk("t4_sat_ovf", {8'b0, ovf_b}, 9'd1);
    en = 1; up_dn = 1;
    #1 chk("t4_sat_tc", {8'b0, tc_b}, 9'd1);
    step(1, 1, 1, 1, 8'd6, 0);
    step(0, 1, 1, 1, 8'd3, 0);
    chk("t5_cnt", obs_c(0), 9'd0);
    chk("t5_ovf", {8'b0, ovf_a}, 9'd0);
    step(1, 1, 1, 1, 8'd255, 0);
    step(1, 1, 1, 0, 0, 1);
    chk("t6_cnt", obs_c(2), 9'd0);
    chk("t6_ovf", {8'b0, ovf_c}, 9'd1);
    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 5) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
